matbi_watch_uart_tx: RTL and testbench
======================================

# matbi_watch_uart_tx

Serial time reporter that sits directly downstream of the watch counter top. It consumes the hour/minute/second outputs and, on every change of the seconds value, transmits one ASCII line "HH:MM:SS\r\n" over a single 8N1 UART TX line. The baud rate is runtime-programmable in clock cycles per bit.

## Interface
Parameters:
- P_SEC_BIT, 6, width of i_sec
- P_MIN_BIT, 6, width of i_min
- P_HOUR_BIT, 5, width of i_hour
- P_DIV_BIT, 16, width of i_baud_div

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- i_run_en  in  1  enables starting new frames
- i_baud_div  in  P_DIV_BIT  clock cycles per UART bit; values 0 and 1 are treated as 2
- i_sec  in  P_SEC_BIT  current seconds, binary
- i_min  in  P_MIN_BIT  current minutes, binary
- i_hour  in  P_HOUR_BIT  current hours, binary
- o_tx  out  1  UART TX line; idle high
- o_busy  out  1  high while a frame is in progress
- o_frame_done  out  1  one-cycle pulse after the last stop bit of a frame
- o_drop  out  1  one-cycle pulse when a seconds change is ignored because a frame is in progress

## Operation
- Change detect: r_prev_sec <= i_sec every cycle. The trigger is (i_sec != r_prev_sec) & i_run_en.
- Trigger in IDLE: latch i_hour, i_min, i_sec and the effective divisor D = max(i_baud_div, 2); start the frame.
- Trigger while not IDLE: o_drop = 1 for that cycle; the snapshot is unchanged and the frame continues.
- Deasserting i_run_en mid-frame does not abort; the frame completes.
- Frame is 10 characters in order: hour tens, hour ones, ':'(0x3A), min tens, min ones, ':', sec tens, sec ones, CR(0x0D), LF(0x0A).
- Digit conversion: tens = value/10, ones = value%10, ASCII = 0x30 + digit. Implement with compare/subtract; no divider. Out-of-range inputs are still converted decimally, e.g. sec 63 gives "63" and hour 31 gives "31".
- Character format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly D cycles.
- FSM states:
  - IDLE: o_tx = 1, o_busy = 0.
  - START -> DATA after D cycles.
  - DATA covers 8 bits, then goes to STOP.
  - STOP -> START if the character index is below 9, else IDLE. The character index increments at the STOP exit.
- Counters: baud counter is P_DIV_BIT wide, bit index is 3 bits, character index is 4 bits (0..9).
- All outputs are registered.

## Timing
- Reset values: o_tx = 1, o_busy = 0, o_frame_done = 0, o_drop = 0, FSM = IDLE, all counters = 0, r_prev_sec = 0.
- Reset mid-frame: the next cycle shows o_tx = 1 and o_busy = 0. No o_frame_done pulse is produced.
- The first cycle after reset does not trigger if i_sec is 0, which matches the upstream reset value.
- Latency: a trigger in cycle N gives o_busy = 1 and o_tx = 0 (start bit) from cycle N+1.
- Frame length is 100*D cycles, so o_busy is high for cycles N+1 .. N+100*D.
- o_frame_done = 1 in cycle N+100*D+1, together with o_busy = 0.
- A trigger in that same cycle N+100*D+1 is accepted, since the FSM is already IDLE.
- i_baud_div changes take effect only at the next frame start.
- A character boundary has no idle gap: the stop bit is followed immediately by the next start bit.

## Test plan
- D=4; hour 12, min 34; i_sec steps 55 -> 56 -> decoded bytes are 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x0D 0x0A; o_busy is high for exactly 400 cycles; o_frame_done is a single pulse at cycle 401 after the trigger.
- Rollover 23:59:59 -> 00:00:00 with D=3 -> frame "00:00:00\r\n" using the latched snapshot, even though the inputs change again during the frame.
- D=4; i_sec changes at trigger+50 and again at trigger+200 -> o_drop pulses exactly twice, only one frame is sent, and the snapshot is unaffected.
- i_baud_div = 0, then = 1 -> each bit lasts 2 cycles and the frame lasts 200 cycles; a divisor change mid-frame does not alter bit widths.
- i_run_en = 0 while i_sec changes -> no frame and no o_drop; dropping i_run_en at trigger+10 -> the frame still completes all 10 characters.
- reset asserted at trigger+123 (D=4) -> o_tx = 1 and o_busy = 0 on the next cycle, with no o_frame_done; after release, the next i_sec change starts a clean full frame.

Source files
------------

// File: rtl/matbi_watch_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : matbi_watch_uart_tx
// Description : Sends one ASCII line "HH:MM:SS\r\n" over an 8N1 UART TX
//               line each time the seconds value changes. Bit time is
//               programmable in clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module matbi_watch_uart_tx #(
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5,
    parameter int P_DIV_BIT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run_en,
    input  logic [P_DIV_BIT-1:0]  i_baud_div,
    input  logic [P_SEC_BIT-1:0]  i_sec,
    input  logic [P_MIN_BIT-1:0]  i_min,
    input  logic [P_HOUR_BIT-1:0] i_hour,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_drop
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    localparam logic [7:0] c_ASCII_COLON = 8'h3A;
    localparam logic [7:0] c_ASCII_CR    = 8'h0D;
    localparam logic [7:0] c_ASCII_LF    = 8'h0A;

    // Two ASCII decimal digits {tens, ones} by repeated compare/subtract.
    // Values above 99 still yield a (non-digit) tens character.
    function automatic logic [15:0] f_to_ascii2(input logic [7:0] value);
        logic [7:0] rem;
        logic [7:0] tens;
        rem  = value;
        tens = 8'd0;
        for (int i = 0; i < 25; i++) begin
            if (rem >= 8'd10) begin
                rem  = rem - 8'd10;
                tens = tens + 8'd1;
            end
        end
        return {8'h30 + tens, 8'h30 + rem};
    endfunction

    logic [1:0]            r_state;
    logic [P_SEC_BIT-1:0]  r_prev_sec;
    logic [P_SEC_BIT-1:0]  r_sec;
    logic [P_MIN_BIT-1:0]  r_min;
    logic [P_HOUR_BIT-1:0] r_hour;
    logic [P_DIV_BIT-1:0]  r_div;
    logic [P_DIV_BIT-1:0]  r_baud_cnt;
    logic [2:0]            r_bit_idx;
    logic [3:0]            r_char_idx;
    logic [7:0]            r_char;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_drop;

    logic                  w_trigger;
    logic [P_DIV_BIT-1:0]  w_eff_div;
    logic                  w_bit_end;
    logic [2:0]            w_bit_nxt;
    logic [3:0]            w_char_nxt_idx;
    logic [7:0]            w_char_nxt;
    logic [15:0]           w_in_hour_asc;
    logic [15:0]           w_hour_asc;
    logic [15:0]           w_min_asc;
    logic [15:0]           w_sec_asc;

    assign w_trigger      = (i_sec != r_prev_sec) && i_run_en;
    assign w_eff_div      = (i_baud_div < P_DIV_BIT'(2)) ? P_DIV_BIT'(2) : i_baud_div;
    assign w_bit_end      = (r_baud_cnt == (r_div - P_DIV_BIT'(1)));
    assign w_bit_nxt      = r_bit_idx + 3'd1;
    assign w_char_nxt_idx = r_char_idx + 4'd1;

    // First character comes straight from the inputs since the snapshot
    // is only being captured in the same cycle.
    assign w_in_hour_asc  = f_to_ascii2(8'(i_hour));
    assign w_hour_asc     = f_to_ascii2(8'(r_hour));
    assign w_min_asc      = f_to_ascii2(8'(r_min));
    assign w_sec_asc      = f_to_ascii2(8'(r_sec));

    // Character that follows the one currently on the line.
    always_comb begin
        w_char_nxt = w_hour_asc[15:8];
        case (w_char_nxt_idx)
            4'd1:    w_char_nxt = w_hour_asc[7:0];
            4'd2:    w_char_nxt = c_ASCII_COLON;
            4'd3:    w_char_nxt = w_min_asc[15:8];
            4'd4:    w_char_nxt = w_min_asc[7:0];
            4'd5:    w_char_nxt = c_ASCII_COLON;
            4'd6:    w_char_nxt = w_sec_asc[15:8];
            4'd7:    w_char_nxt = w_sec_asc[7:0];
            4'd8:    w_char_nxt = c_ASCII_CR;
            4'd9:    w_char_nxt = c_ASCII_LF;
            default: w_char_nxt = w_hour_asc[15:8];
        endcase
    end

    // Change detect, snapshot capture and the UART frame state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_prev_sec   <= '0;
            r_sec        <= '0;
            r_min        <= '0;
            r_hour       <= '0;
            r_div        <= '0;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_char_idx   <= '0;
            r_char       <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_prev_sec   <= i_sec;
            r_frame_done <= 1'b0;
            r_drop       <= w_trigger && (r_state != c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_trigger) begin
                        r_sec      <= i_sec;
                        r_min      <= i_min;
                        r_hour     <= i_hour;
                        r_div      <= w_eff_div;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_char_idx <= '0;
                        r_char     <= w_in_hour_asc[15:8];
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_char[0];
                        r_state    <= c_ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + P_DIV_BIT'(1);
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit_idx <= w_bit_nxt;
                            r_tx      <= r_char[w_bit_nxt];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + P_DIV_BIT'(1);
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_char_idx == 4'd9) begin
                            r_char_idx   <= '0;
                            r_tx         <= 1'b1;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= c_ST_IDLE;
                        end else begin
                            r_char_idx <= w_char_nxt_idx;
                            r_char     <= w_char_nxt;
                            r_tx       <= 1'b0;
                            r_state    <= c_ST_START;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + P_DIV_BIT'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_drop       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_matbi_watch_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_matbi_watch_uart_tx
// Description : Self-checking bench for matbi_watch_uart_tx. Frames are
//               captured sample-per-cycle and decoded against expected text.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matbi_watch_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_run_en;
    logic [15:0] i_baud_div;
    logic [5:0]  i_sec;
    logic [5:0]  i_min;
    logic [4:0]  i_hour;
    logic        o_tx;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_drop;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  hour;
        logic [5:0]  min;
        logic [5:0]  sec0;
        logic [5:0]  sec1;
        logic [15:0] div;
        int          d;
        logic [63:0] text;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    matbi_watch_uart_tx #(
        .P_SEC_BIT (6),
        .P_MIN_BIT (6),
        .P_HOUR_BIT(5),
        .P_DIV_BIT (16)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .i_run_en    (i_run_en),
        .i_baud_div  (i_baud_div),
        .i_sec       (i_sec),
        .i_min       (i_min),
        .i_hour      (i_hour),
        .o_tx        (o_tx),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done),
        .o_drop      (o_drop)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge where the trigger has just been driven. Returns at
    // the negedge of cycle trigger+100*d+1. Mid-frame actions fire at the
    // given cycle offsets (-1 = never).
    task automatic capture_frame(input string nm, input int d, input logic [63:0] text,
                                 input int sec_a, input int sec_b, input int hm_at,
                                 input int runen_off_at, input int div_at, input int exp_drops);
        logic       tx_s [$];
        logic [7:0] exp_b [10];
        logic [7:0] got;
        int         busy_bad;
        int         done_bad;
        int         drops;
        int         width_bad;
        int         frame_bad;
        int         n;
        int         base;
        busy_bad  = 0;
        done_bad  = 0;
        drops     = 0;
        width_bad = 0;
        frame_bad = 0;
        n         = 100 * d;
        for (int c = 0; c < 8; c++) exp_b[c] = text[63-8*c -: 8];
        exp_b[8] = 8'h0D;
        exp_b[9] = 8'h0A;
        @(posedge clk);
        @(negedge clk);
        for (int t = 1; t <= n; t++) begin
            if (o_busy !== 1'b1) busy_bad++;
            if (o_frame_done !== 1'b0) done_bad++;
            if (o_drop === 1'b1) drops++;
            tx_s.push_back(o_tx);
            if (t == sec_a || t == sec_b) i_sec = i_sec + 6'd1;
            if (t == hm_at) begin
                i_hour = 5'd11;
                i_min  = 6'd11;
            end
            if (t == runen_off_at) i_run_en = 1'b0;
            if (t == div_at) i_baud_div = 16'd7;
            @(negedge clk);
        end
        if (o_drop === 1'b1) drops++;
        check({nm, " busy_window"}, busy_bad, 0);
        check({nm, " early_done"}, done_bad, 0);
        check({nm, " busy_end"}, {31'd0, o_busy}, 0);
        check({nm, " done_pulse"}, {31'd0, o_frame_done}, 1);
        check({nm, " drops"}, drops, exp_drops);
        for (int c = 0; c < 10; c++) begin
            got = 8'd0;
            for (int b = 0; b < 10; b++) begin
                base = (c * 10 + b) * d;
                for (int k = 1; k < d; k++)
                    if (tx_s[base+k] !== tx_s[base]) width_bad++;
                if (b == 0 && tx_s[base] !== 1'b0) frame_bad++;
                if (b == 9 && tx_s[base] !== 1'b1) frame_bad++;
                if (b >= 1 && b <= 8) got[b-1] = tx_s[base];
            end
            check($sformatf("%s char%0d", nm, c), {24'd0, got}, {24'd0, exp_b[c]});
        end
        check({nm, " bit_width"}, width_bad, 0);
        check({nm, " start_stop"}, frame_bad, 0);
    endtask

    // Load time/divisor with run disabled so no frame starts, then re-enable.
    task automatic setup_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                              input logic [15:0] div);
        i_run_en   = 1'b0;
        i_hour     = h;
        i_min      = m;
        i_sec      = s;
        i_baud_div = div;
        repeat (2) @(negedge clk);
        i_run_en = 1'b1;
        @(negedge clk);
        check("idle_before_trigger", {31'd0, o_busy}, 0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{5'd12, 6'd34, 6'd55, 6'd56, 16'd4, 4, "12:34:56"};
        vecs[1] = '{5'd23, 6'd59, 6'd58, 6'd59, 16'd5, 5, "23:59:59"};
        vecs[2] = '{5'd31, 6'd60, 6'd62, 6'd63, 16'd3, 3, "31:60:63"};
        vecs[3] = '{5'd7,  6'd5,  6'd8,  6'd9,  16'd2, 2, "07:05:09"};

        reset      = 1'b1;
        i_run_en   = 1'b1;
        i_baud_div = 16'd4;
        i_sec      = 6'd0;
        i_min      = 6'd0;
        i_hour     = 5'd0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, o_tx}, 1);
        check("reset_busy", {31'd0, o_busy}, 0);
        check("reset_done", {31'd0, o_frame_done}, 0);
        check("reset_drop", {31'd0, o_drop}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("no_trigger_after_reset", {31'd0, o_busy}, 0);

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            setup_time(vecs[v].hour, vecs[v].min, vecs[v].sec0, vecs[v].div);
            i_sec = vecs[v].sec1;
            capture_frame($sformatf("vec%0d", v), vecs[v].d, vecs[v].text, -1, -1, -1, -1, -1, 0);
        end

        // Rollover with inputs moving during the frame.
        setup_time(5'd23, 6'd59, 6'd59, 16'd3);
        i_hour = 5'd0;
        i_min  = 6'd0;
        i_sec  = 6'd0;
        capture_frame("rollover", 3, "00:00:00", 40, -1, 60, -1, -1, 1);

        // Two seconds changes mid-frame are dropped.
        setup_time(5'd12, 6'd34, 6'd10, 16'd4);
        i_sec = 6'd11;
        capture_frame("drop", 4, "12:34:11", 50, 200, -1, -1, -1, 2);
        @(negedge clk);
        check("drop_no_second_frame", {31'd0, o_busy}, 0);

        // Divisor 0 with mid-frame change, then divisor 1 back-to-back in
        // the frame_done cycle.
        setup_time(5'd1, 6'd2, 6'd3, 16'd0);
        i_sec = 6'd4;
        capture_frame("div0", 2, "01:02:04", -1, -1, -1, -1, 50, 0);
        i_baud_div = 16'd1;
        i_sec      = 6'd5;
        capture_frame("div1_b2b", 2, "01:02:05", -1, -1, -1, -1, -1, 0);

        // Run disabled: seconds changes are ignored entirely.
        i_run_en = 1'b0;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            if (t % 3 == 0) i_sec = i_sec + 6'd1;
            @(negedge clk);
            if (o_busy !== 1'b0 || o_drop !== 1'b0) bad++;
        end
        check("run_en_off_quiet", bad, 0);

        // Run dropped mid-frame: frame still completes.
        setup_time(5'd12, 6'd34, 6'd40, 16'd4);
        i_sec = 6'd41;
        capture_frame("runen_mid", 4, "12:34:41", -1, -1, -1, 10, -1, 0);

        // Reset mid-frame at trigger+123.
        setup_time(5'd12, 6'd34, 6'd20, 16'd4);
        i_sec = 6'd21;
        @(posedge clk);
        @(negedge clk);
        for (int t = 1; t < 123; t++) @(negedge clk);
        reset = 1'b1;
        i_sec = 6'd0;
        @(negedge clk);
        check("midreset_tx", {31'd0, o_tx}, 1);
        check("midreset_busy", {31'd0, o_busy}, 0);
        check("midreset_done", {31'd0, o_frame_done}, 0);
        reset = 1'b0;
        bad   = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (o_busy !== 1'b0 || o_frame_done !== 1'b0) bad++;
        end
        check("post_reset_quiet", bad, 0);
        i_sec = 6'd1;
        capture_frame("after_reset", 4, "12:34:01", -1, -1, -1, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
